data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-state data memory responder for a CPU datapath
//
// Single-port word RAM behind a request/acknowledge handshake. A request is
// latched in IDLE, held for WAIT_CYCLES wait states, then completed on the edge
// entering RESP, where mem_ack is raised for one cycle.
//
// Ports:
//   clk       in   clock, all state changes on the rising edge
//   rst       in   synchronous active-high reset
//   mem_ren   in   read request, held until mem_ack
//   mem_wen   in   write request, held until mem_ack
//   mem_addr  in   32-bit byte address
//   mem_dout  in   32-bit write data from the CPU
//   mem_din   out  registered read data, held until the next completed read
//   mem_ack   out  registered one-cycle completion pulse
//   mem_busy  out  request in flight (WAIT or RESP)
//   mem_err   out  sticky error: misaligned, out-of-range or read+write together
//   rd_cnt    out  saturating count of valid completed reads
//   wr_cnt    out  saturating count of valid completed writes

module data_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        mem_ack,
    output logic        mem_busy,
    output logic        mem_err,
    output logic [15:0] rd_cnt,
    output logic [15:0] wr_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int          DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES - 1);
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    state_t                  state_q, state_d;
    logic [3:0]              wcnt_q, wcnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             data_q, data_d;
    logic                    wr_q, wr_d;
    logic                    bad_q, bad_d;
    logic                    both_q, both_d;
    logic [31:0]             din_q, din_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic [15:0]             rd_cnt_q, rd_cnt_d;
    logic [15:0]             wr_cnt_q, wr_cnt_d;

    logic                    enter_resp;
    logic                    ram_we;
    logic                    misaligned;
    logic                    out_of_range;
    logic [31:0]             ram_rdata;

    logic [31:0]             ram_q [DEPTH];

    assign misaligned   = (mem_addr[1:0] != 2'b00);
    assign out_of_range = ((mem_addr >> (ADDR_WIDTH + 2)) != 32'd0);

    // The access uses the *_d copies so that the zero-wait path (IDLE straight
    // to RESP) sees the request being accepted on this same edge.
    assign ram_rdata = ram_q[addr_d];

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_d       = wr_q;
        bad_d      = bad_q;
        both_d     = both_q;
        din_d      = din_q;
        ack_d      = 1'b0;
        err_d      = err_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        enter_resp = 1'b0;
        ram_we     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_ren || mem_wen) begin
                    addr_d = mem_addr[ADDR_WIDTH+1:2];
                    data_d = mem_dout;
                    wr_d   = mem_wen;
                    bad_d  = misaligned || out_of_range;
                    both_d = mem_ren && mem_wen;
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        wcnt_d  = WAIT_LOAD;
                    end else begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (wcnt_q == 4'd0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (enter_resp) begin
            ack_d = 1'b1;
            if (bad_d || both_d) begin
                err_d = 1'b1;
            end
            if (wr_d) begin
                // Read+write together still writes, but is not a clean access.
                ram_we = !bad_d;
                if (!bad_d && !both_d && (wr_cnt_q != CNT_MAX)) begin
                    wr_cnt_d = wr_cnt_q + 16'd1;
                end
            end else begin
                din_d = bad_d ? 32'd0 : ram_rdata;
                if (!bad_d && (rd_cnt_q != CNT_MAX)) begin
                    rd_cnt_d = rd_cnt_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wcnt_q   <= 4'd0;
            addr_q   <= '0;
            data_q   <= 32'd0;
            wr_q     <= 1'b0;
            bad_q    <= 1'b0;
            both_q   <= 1'b0;
            din_q    <= 32'd0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rd_cnt_q <= 16'd0;
            wr_cnt_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            wr_q     <= wr_d;
            bad_q    <= bad_d;
            both_q   <= both_d;
            din_q    <= din_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // RAM contents survive reset; only the write itself is suppressed.
    always_ff @(posedge clk) begin
        if (ram_we && !rst) begin
            ram_q[addr_d] <= data_d;
        end
    end

    assign mem_din  = din_q;
    assign mem_ack  = ack_q;
    assign mem_busy = (state_q != ST_IDLE);
    assign mem_err  = err_q;
    assign rd_cnt   = rd_cnt_q;
    assign wr_cnt   = wr_cnt_q;

endmodule
